irq_flag_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the CPU flag register. It latches and prioritises external interrupt requests, and tells the control unit when to take one. On entry it pushes the live carry/zero flags onto a shadow stack. On return-from-interrupt it pops them and drives the flag register's interrupt write port (iwe, intc_i, intz_i) so the interrupted code resumes with its own flags.

---
 rtl/irq_flag_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_flag_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_flag_ctrl.sv
// Interrupt controller feeding the CPU flag register: latches/prioritises IRQs and
// saves/restores carry/zero across handlers. Define IRQ_FLAG_NEST_EN for nesting/preemption.
module irq_flag_ctrl #(
  parameter int unsigned       NUM_IRQ     = 4,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter int unsigned       VEC_W       = 8,
  parameter logic [VEC_W-1:0]  VEC_BASE    = 8'h10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clk_en,
  input  logic [NUM_IRQ-1:0]               irq_i,
  input  logic                             mask_we,
  input  logic [NUM_IRQ-1:0]               mask_i,
  input  logic                             boundary_i,
  input  logic                             reti_i,
  input  logic                             c_i,
  input  logic                             z_i,
  output logic                             take_o,
  output logic [VEC_W-1:0]                 vec_o,
  output logic                             iwe_o,
  output logic                             intc_o,
  output logic                             intz_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth_o,
  output logic                             err_o
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
`ifdef IRQ_FLAG_NEST_EN
  localparam int unsigned EffDepth = STACK_DEPTH;
`else
  localparam int unsigned EffDepth = 1;
`endif

  typedef enum logic [1:0] {StRun, StEntry, StRestore} state_e;

  state_e              state_q;
  logic [NUM_IRQ-1:0]  irq_prev_q, pend_q, insvc_q, mask_q;
  logic [1:0]          stack_q [EffDepth];
  logic [DepthW-1:0]   depth_q;
  logic [1:0]          flags_q;
  logic [IdxW-1:0]     sel_q;
  logic                take_q, iwe_q, intc_q, intz_q, err_q;
  logic [VEC_W-1:0]    vec_q;

  logic [NUM_IRQ-1:0]  rise, allowed, elig, clr, insvc_low;
  logic [IdxW-1:0]     sel;
  logic [1:0]          top;
  logic                blocked, can_take;

  assign rise = irq_i & ~irq_prev_q;

  // Only IRQs strictly higher in priority than every in-service IRQ may preempt.
  always_comb begin
    allowed = '0;
    blocked = 1'b0;
`ifdef IRQ_FLAG_NEST_EN
    for (int i = 0; i < NUM_IRQ; i++) begin
      blocked    = blocked | insvc_q[i];
      allowed[i] = ~blocked;
    end
`else
    allowed = (insvc_q == '0) ? '1 : '0;
`endif
  end

  assign elig     = pend_q & mask_q & allowed;
  assign can_take = (|elig) && (depth_q < DepthW'(EffDepth));

  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = IdxW'(i);
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < EffDepth; i++) begin
      if (depth_q == DepthW'(i + 1)) top = stack_q[i];
    end
  end

  assign clr       = (state_q == StEntry) ? (NUM_IRQ'(1) << sel_q) : '0;
  assign insvc_low = insvc_q & (~insvc_q + NUM_IRQ'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      irq_prev_q <= '0;
      pend_q     <= '0;
      insvc_q    <= '0;
      mask_q     <= '0;
      depth_q    <= '0;
      flags_q    <= '0;
      sel_q      <= '0;
      take_q     <= 1'b0;
      iwe_q      <= 1'b0;
      intc_q     <= 1'b0;
      intz_q     <= 1'b0;
      err_q      <= 1'b0;
      vec_q      <= '0;
      for (int unsigned i = 0; i < EffDepth; i++) stack_q[i] <= '0;
    end else if (clk_en) begin
      irq_prev_q <= irq_i;
      // A fresh edge on the line being taken re-arms it rather than being lost.
      pend_q     <= (pend_q & ~clr) | rise;
      if (mask_we) mask_q <= mask_i;
      unique case (state_q)
        StRun: begin
          if (reti_i) begin
            if (depth_q == '0) begin
              err_q <= 1'b1;
            end else begin
              state_q          <= StRestore;
              iwe_q            <= 1'b1;
              {intc_q, intz_q} <= top;
            end
          end else if (boundary_i && can_take) begin
            state_q <= StEntry;
            take_q  <= 1'b1;
            sel_q   <= sel;
            vec_q   <= VEC_BASE + (VEC_W'(sel) << 2);
            flags_q <= {c_i, z_i};
          end
        end
        StEntry: begin
          for (int unsigned i = 0; i < EffDepth; i++) begin
            if (depth_q == DepthW'(i)) stack_q[i] <= flags_q;
          end
          insvc_q <= insvc_q | clr;
          depth_q <= depth_q + DepthW'(1);
          take_q  <= 1'b0;
          state_q <= StRun;
        end
        StRestore: begin
          insvc_q <= insvc_q & ~insvc_low;
          depth_q <= depth_q - DepthW'(1);
          iwe_q   <= 1'b0;
          state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign take_o  = take_q;
  assign vec_o   = vec_q;
  assign iwe_o   = iwe_q;
  assign intc_o  = intc_q;
  assign intz_o  = intz_q;
  assign depth_o = depth_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_irq_flag_ctrl.sv
// Randomised scoreboard bench for irq_flag_ctrl against a queue-based behavioural model.
module tb_irq_flag_ctrl;

  localparam int NUM = 4;
`ifdef IRQ_FLAG_NEST_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0, rst = 1'b0, clk_en = 1'b1;
  logic [3:0] irq_i = '0, mask_i = '0;
  logic       mask_we = 1'b0, boundary_i = 1'b0, reti_i = 1'b0, c_i = 1'b0, z_i = 1'b0;
  logic       take_o, iwe_o, intc_o, intz_o, err_o;
  logic [7:0] vec_o;
  logic [2:0] depth_o;

  irq_flag_ctrl dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .irq_i(irq_i), .mask_we(mask_we),
    .mask_i(mask_i), .boundary_i(boundary_i), .reti_i(reti_i), .c_i(c_i), .z_i(z_i),
    .take_o(take_o), .vec_o(vec_o), .iwe_o(iwe_o), .intc_o(intc_o), .intz_o(intz_o),
    .depth_o(depth_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_take;
    logic [7:0] vec;
    bit         c;
    bit         z;
    int         cyc;
  } ev_t;

  ev_t  exq[$];
  int   checks = 0, errors = 0;

  // Reference model: in-service IRQs and saved flags kept as plain queues.
  int         m_svc[$];
  logic [1:0] m_fstk[$];
  logic [3:0] m_pend, m_prev, m_mask;
  bit         m_err, m_en_last;
  int         m_phase;  // 0 running, 1 taking, 2 returning
  int         m_ent_idx, m_cyc;
  logic [1:0] m_ent_flags;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  function automatic void m_reset();
    m_svc.delete(); m_fstk.delete(); exq.delete();
    m_pend = '0; m_prev = '0; m_mask = '0; m_err = 0; m_phase = 0;
  endfunction

  function automatic bool_higher(int k);
    foreach (m_svc[j]) if (m_svc[j] <= k) return 0;
    return 1;
  endfunction

  function automatic void m_step();
    ev_t e;
    logic [3:0] rise;
    int best, lo, loj;
    m_cyc++;
    rise = irq_i & ~m_prev;
    if (m_phase == 1) begin
      m_svc.push_back(m_ent_idx);
      m_fstk.push_back(m_ent_flags);
      m_pend[m_ent_idx] = 1'b0;
      m_phase = 0;
    end else if (m_phase == 2) begin
      lo = 99; loj = 0;
      foreach (m_svc[j]) if (m_svc[j] < lo) begin lo = m_svc[j]; loj = j; end
      m_svc.delete(loj);
      void'(m_fstk.pop_back());
      m_phase = 0;
    end else if (reti_i) begin
      if (m_svc.size() == 0) m_err = 1;
      else begin
        e.is_take = 0; e.vec = '0; e.c = m_fstk[$][1]; e.z = m_fstk[$][0]; e.cyc = m_cyc;
        exq.push_back(e);
        m_phase = 2;
      end
    end else if (boundary_i && m_svc.size() < CAP) begin
      best = -1;
      for (int k = NUM - 1; k >= 0; k--)
        if (m_pend[k] && m_mask[k] && bool_higher(k)) best = k;
      if (best >= 0) begin
        e.is_take = 1; e.vec = BASE + 8'(4 * best); e.c = 0; e.z = 0; e.cyc = m_cyc;
        exq.push_back(e);
        m_phase = 1; m_ent_idx = best; m_ent_flags = {c_i, z_i};
      end
    end
    m_pend = m_pend | rise;
    m_prev = irq_i;
    if (mask_we) m_mask = mask_i;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_reset();
      m_en_last = 0;
    end else begin
      m_en_last = clk_en;
      if (clk_en) m_step();
    end
  end

  // Monitor: per-cycle state checks plus scoreboard pop on every fresh output pulse.
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      chk("take_o", {31'b0, take_o}, {31'b0, m_phase == 1});
      chk("iwe_o", {31'b0, iwe_o}, {31'b0, m_phase == 2});
      chk("depth_o", {29'b0, depth_o}, m_svc.size());
      chk("err_o", {31'b0, err_o}, {31'b0, m_err});
      if (m_en_last && (take_o || iwe_o)) begin
        if (exq.size() == 0) begin
          checks++; errors++;
          $display("FAIL event: got take=%0b iwe=%0b expected no event", take_o, iwe_o);
        end else begin
          e = exq.pop_front();
          chk("event_kind", {31'b0, take_o}, {31'b0, e.is_take});
          chk("event_cycle", m_cyc, e.cyc);
          if (e.is_take) chk("vec_o", {24'b0, vec_o}, {24'b0, e.vec});
          else chk("restored_cz", {30'b0, intc_o, intz_o}, {30'b0, e.c, e.z});
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_irq(int k);
    irq_i[k] = 1'b1; cyc(1); irq_i[k] = 1'b0;
  endtask

  task automatic reti();
    reti_i = 1'b1; cyc(1); reti_i = 1'b0; cyc(3);
  endtask

  task automatic wait_take(string name);
    int n = 0;
    while (!take_o && n < 12) begin cyc(1); n++; end
    if (!take_o) begin
      checks++; errors++;
      $display("FAIL %s: got no take_o expected take_o within 12 cycles", name);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_take", {31'b0, take_o}, 0);
    chk("rst_iwe", {31'b0, iwe_o}, 0);
    chk("rst_vec", {24'b0, vec_o}, 0);
    chk("rst_depth", {29'b0, depth_o}, 0);
    chk("rst_err", {30'b0, intc_o, err_o}, 0);
    rst = 1'b1;
    mask_we = 1'b1; mask_i = 4'hF; cyc(1); mask_we = 1'b0;

    // Single IRQ
    c_i = 1; z_i = 0; boundary_i = 1;
    pulse_irq(2); cyc(4);
    boundary_i = 0; reti();

    // Priority
    boundary_i = 1;
    irq_i = 4'b1010; cyc(1); irq_i = '0; cyc(4);
    reti(); cyc(2); reti();

    // Nesting / preemption
    c_i = 1; z_i = 1; pulse_irq(3); cyc(4);
    c_i = 0; z_i = 1; pulse_irq(0); cyc(4);
    reti(); cyc(2); reti(); cyc(2);

    // Full stack, then one more request that must wait
    pulse_irq(3); cyc(3); pulse_irq(2); cyc(3); pulse_irq(1); cyc(3); pulse_irq(0); cyc(3);
    pulse_irq(3); cyc(4);
    repeat (6) reti();

    // Simultaneous reti and eligible IRQ
    pulse_irq(3); cyc(4); boundary_i = 0;
    pulse_irq(1); cyc(2);
    reti_i = 1; boundary_i = 1; cyc(1); reti_i = 0; cyc(5);
    repeat (3) reti();

    // Underflow, then clock gating during a take
    boundary_i = 0; reti(); reti();
    boundary_i = 1; pulse_irq(2); wait_take("gate_take");
    clk_en = 0; cyc(3); clk_en = 1; cyc(2);
    reti();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) irq_i = irq_i ^ 4'($urandom);
      boundary_i = ($urandom_range(0, 3) != 0);
      reti_i     = ($urandom_range(0, 7) == 0);
      mask_we    = ($urandom_range(0, 29) == 0);
      mask_i     = 4'($urandom);
      c_i        = 1'($urandom);
      z_i        = 1'($urandom);
      clk_en     = ($urandom_range(0, 9) != 0);
      cyc(1);
    end
    irq_i = '0; boundary_i = 0; reti_i = 0; mask_we = 0; clk_en = 1; cyc(3);
    repeat (6) reti();
    chk("queue_empty", exq.size(), 0);

    // Reset during a take aborts it
    mask_we = 1; mask_i = 4'hF; cyc(1); mask_we = 0;
    boundary_i = 1; pulse_irq(1); wait_take("abort_take");
    rst = 0; #1;
    chk("abort_take_o", {31'b0, take_o}, 0);
    chk("abort_depth", {29'b0, depth_o}, 0);
    cyc(1); rst = 1; boundary_i = 0; cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
